// File: rtl/vend_dispense_ctrl_if.sv
// Request/dispense bundle between the vending FSM (master) and the dispense
// sequencer (slave); clk and rst stay outside the bundle.
interface vend_dispense_ctrl_if #(
    parameter int N_SLOTS = 4,
    parameter int SLOT_W  = 2,
    parameter int CHG_W   = 4
);
    logic               req_valid;
    logic               req_ready;
    logic [SLOT_W-1:0]  req_slot;
    logic [CHG_W-1:0]   req_change;
    logic [CHG_W-1:0]   req_refund;
    logic               drop_sense;
    logic [N_SLOTS-1:0] motor_en;
    logic               coin_out;
    logic               busy;
    logic               done;
    logic               jam;

    modport master (
        output req_valid, req_slot, req_change, req_refund, drop_sense,
        input  req_ready, motor_en, coin_out, busy, done, jam
    );

    modport slave (
        input  req_valid, req_slot, req_change, req_refund, drop_sense,
        output req_ready, motor_en, coin_out, busy, done, jam
    );
endinterface

// File: rtl/vend_dispense_ctrl.sv
// Dispense sequencer: motor pulse, drop wait with jam timeout, coin payout.
// Optional macro VEND_JAM_RETRY_EN adds one extra motor burst before declaring a jam.
module vend_dispense_ctrl #(
    parameter int N_SLOTS      = 4,
    parameter int SLOT_W       = 2,
    parameter int CHG_W        = 4,
    parameter int MOTOR_CYCLES = 8,
    parameter int DROP_TIMEOUT = 64,
    parameter int COIN_GAP     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    vend_dispense_ctrl_if.slave  bus
);

    localparam int MC_W = $clog2(MOTOR_CYCLES + 1);
    localparam int WT_W = $clog2(DROP_TIMEOUT + 1);
    localparam int GP_W = $clog2(COIN_GAP + 1);
    localparam logic [MC_W-1:0] MC_LAST = MC_W'(MOTOR_CYCLES - 1);
    localparam logic [WT_W-1:0] WT_LAST = WT_W'(DROP_TIMEOUT - 1);
    localparam logic [GP_W-1:0] GP_LAST = GP_W'(COIN_GAP - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_MOTOR,
        S_WAIT_DROP,
        S_PAY,
        S_GAP,
        S_DONE
    } state_t;

    state_t             state_q, state_d;
    logic [SLOT_W-1:0]  slot_q, slot_d;
    logic [CHG_W-1:0]   change_q, change_d;
    logic [CHG_W-1:0]   refund_q, refund_d;
    logic [CHG_W-1:0]   coin_cnt_q, coin_cnt_d;
    logic [MC_W-1:0]    motor_cnt_q, motor_cnt_d;
    logic [WT_W-1:0]    wait_cnt_q, wait_cnt_d;
    logic [GP_W-1:0]    gap_cnt_q, gap_cnt_d;
    logic               drop_seen_q, drop_seen_d;
    logic               jam_q, jam_d;
    logic               req_ready_q, req_ready_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               coin_out_q, coin_out_d;
    logic [N_SLOTS-1:0] motor_en_q, motor_en_d;
`ifdef VEND_JAM_RETRY_EN
    logic               retry_q, retry_d;
`endif

    // Out-of-range slot indices decode to no motor bit at all.
    function automatic logic [N_SLOTS-1:0] slot_onehot(input logic [SLOT_W-1:0] s);
        logic [N_SLOTS-1:0] oh;
        oh = '0;
        for (int i = 0; i < N_SLOTS; i++) begin
            if (int'(s) == i) oh[i] = 1'b1;
        end
        return oh;
    endfunction

    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        change_d    = change_q;
        refund_d    = refund_q;
        coin_cnt_d  = coin_cnt_q;
        motor_cnt_d = motor_cnt_q;
        wait_cnt_d  = wait_cnt_q;
        gap_cnt_d   = gap_cnt_q;
        drop_seen_d = drop_seen_q;
        jam_d       = jam_q;
`ifdef VEND_JAM_RETRY_EN
        retry_d     = retry_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (bus.req_valid && req_ready_q) begin
                    slot_d      = bus.req_slot;
                    change_d    = bus.req_change;
                    refund_d    = bus.req_refund;
                    jam_d       = 1'b0;
                    drop_seen_d = 1'b0;
                    motor_cnt_d = '0;
                    wait_cnt_d  = '0;
`ifdef VEND_JAM_RETRY_EN
                    retry_d     = 1'b0;
`endif
                    state_d     = S_MOTOR;
                end
            end

            S_MOTOR: begin
                if (bus.drop_sense) drop_seen_d = 1'b1;
                if (motor_cnt_q == MC_LAST) begin
                    motor_cnt_d = '0;
                    wait_cnt_d  = '0;
                    state_d     = S_WAIT_DROP;
                end else begin
                    motor_cnt_d = motor_cnt_q + MC_W'(1);
                end
            end

            // A drop on the final timeout cycle still counts as success.
            S_WAIT_DROP: begin
                if (drop_seen_q || bus.drop_sense) begin
                    coin_cnt_d = change_q;
                    state_d    = S_PAY;
                end else if (wait_cnt_q == WT_LAST) begin
`ifdef VEND_JAM_RETRY_EN
                    if (!retry_q) begin
                        retry_d     = 1'b1;
                        wait_cnt_d  = '0;
                        motor_cnt_d = '0;
                        state_d     = S_MOTOR;
                    end else begin
                        jam_d      = 1'b1;
                        coin_cnt_d = refund_q;
                        state_d    = S_PAY;
                    end
`else
                    jam_d      = 1'b1;
                    coin_cnt_d = refund_q;
                    state_d    = S_PAY;
`endif
                end else begin
                    wait_cnt_d = wait_cnt_q + WT_W'(1);
                end
            end

            S_PAY: begin
                if (coin_cnt_q == '0) begin
                    state_d = S_DONE;
                end else begin
                    coin_cnt_d = coin_cnt_q - CHG_W'(1);
                    gap_cnt_d  = '0;
                    state_d    = S_GAP;
                end
            end

            S_GAP: begin
                if (gap_cnt_q == GP_LAST) begin
                    state_d = S_PAY;
                end else begin
                    gap_cnt_d = gap_cnt_q + GP_W'(1);
                end
            end

            S_DONE: state_d = S_IDLE;

            default: state_d = S_IDLE;
        endcase

        // Outputs are decoded from the next state so every port is a flop.
        req_ready_d = (state_d == S_IDLE);
        busy_d      = (state_d != S_IDLE);
        done_d      = (state_d == S_DONE);
        motor_en_d  = (state_d == S_MOTOR) ? slot_onehot(slot_d) : '0;
        coin_out_d  = (state_d == S_PAY) && (coin_cnt_d != '0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_IDLE;
            coin_cnt_q  <= '0;
            motor_cnt_q <= '0;
            wait_cnt_q  <= '0;
            gap_cnt_q   <= '0;
            drop_seen_q <= 1'b0;
            jam_q       <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            coin_out_q  <= 1'b0;
            motor_en_q  <= '0;
`ifdef VEND_JAM_RETRY_EN
            retry_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            coin_cnt_q  <= coin_cnt_d;
            motor_cnt_q <= motor_cnt_d;
            wait_cnt_q  <= wait_cnt_d;
            gap_cnt_q   <= gap_cnt_d;
            drop_seen_q <= drop_seen_d;
            jam_q       <= jam_d;
            req_ready_q <= req_ready_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            coin_out_q  <= coin_out_d;
            motor_en_q  <= motor_en_d;
`ifdef VEND_JAM_RETRY_EN
            retry_q     <= retry_d;
`endif
        end
    end

    // Captured request fields are only read after an accept reloads them.
    always_ff @(posedge clk) begin
        slot_q   <= slot_d;
        change_q <= change_d;
        refund_q <= refund_d;
    end

    assign bus.req_ready = req_ready_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.jam       = jam_q;
    assign bus.coin_out  = coin_out_q;
    assign bus.motor_en  = motor_en_q;

endmodule

// File: tb/tb_vend_dispense_ctrl.sv
// Bench for vend_dispense_ctrl: directed and random vends checked against a
// timeline model derived from the phase durations.
module tb_vend_dispense_ctrl;

    localparam int N_SLOTS = 4;
    localparam int SLOT_W  = 2;
    localparam int CHG_W   = 4;
    localparam int M       = 8;
    localparam int T       = 64;
    localparam int G       = 4;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   cur_s;

    vend_dispense_ctrl_if #(.N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .CHG_W(CHG_W)) vif ();

    vend_dispense_ctrl #(
        .N_SLOTS(N_SLOTS), .SLOT_W(SLOT_W), .CHG_W(CHG_W),
        .MOTOR_CYCLES(M), .DROP_TIMEOUT(T), .COIN_GAP(G)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s at step %0d: observed %0h expected %0h", tag, cur_s, obs, exp);
        end
    endtask

    // d = first cycle (counted from the accept edge) with drop_sense high, -1 for never.
    task automatic run_txn(input int slot, input int chg, input int rfd, input int d,
                           input int dlen, input bit hold, input int abort_at);
        int pay, n, done_s, m2s, m2e;
        bit jm;
        logic [N_SLOTS-1:0] oh;
        oh = '0;
        if (slot < N_SLOTS) oh[slot] = 1'b1;
        jm  = 1'b0;
        m2s = -1;
        m2e = -2;
        if (d >= 0 && d < M) pay = M + 1;
        else if (d >= M && d < M + T) pay = d + 1;
        else begin
`ifdef VEND_JAM_RETRY_EN
            m2s = M + T;
            m2e = 2 * M + T - 1;
            if (d >= m2s && d <= m2e) pay = 2 * M + T + 1;
            else if (d > m2e && d < 2 * M + 2 * T) pay = d + 1;
            else begin
                jm  = 1'b1;
                pay = 2 * M + 2 * T;
            end
`else
            jm  = 1'b1;
            pay = M + T;
`endif
        end
        n      = jm ? rfd : chg;
        done_s = pay + n * (G + 1) + 1;

        vif.req_valid  = 1'b1;
        vif.req_slot   = SLOT_W'(slot);
        vif.req_change = CHG_W'(chg);
        vif.req_refund = CHG_W'(rfd);
        vif.drop_sense = 1'b0;
        @(posedge clk);
        for (int s = 0; s <= done_s + 1; s++) begin
            @(negedge clk);
            cur_s = s;
            check("motor_en", 32'(vif.motor_en),
                  32'(((s < M) || (s >= m2s && s <= m2e)) ? oh : '0));
            check("coin_out", 32'(vif.coin_out),
                  32'(s >= pay && s < pay + n * (G + 1) && ((s - pay) % (G + 1)) == 0));
            check("busy", 32'(vif.busy), 32'(s <= done_s));
            check("req_ready", 32'(vif.req_ready), 32'(s > done_s));
            check("done", 32'(vif.done), 32'(s == done_s));
            check("jam", 32'(vif.jam), 32'((s >= pay) ? jm : 1'b0));
            if (s == abort_at || s == done_s + 1) break;
            vif.drop_sense = (d >= 0 && s >= d && s < d + dlen);
            vif.req_valid  = hold;
            if (hold) begin
                vif.req_slot   = SLOT_W'($urandom_range(0, N_SLOTS - 1));
                vif.req_change = CHG_W'($urandom_range(0, 15));
            end
            @(posedge clk);
        end
        vif.req_valid  = 1'b0;
        vif.drop_sense = 1'b0;
    endtask

    task automatic check_reset_outputs();
        check("rst_req_ready", 32'(vif.req_ready), 32'd1);
        check("rst_motor_en", 32'(vif.motor_en), 32'd0);
        check("rst_coin_out", 32'(vif.coin_out), 32'd0);
        check("rst_busy", 32'(vif.busy), 32'd0);
        check("rst_done", 32'(vif.done), 32'd0);
        check("rst_jam", 32'(vif.jam), 32'd0);
    endtask

    initial begin
        int slot, chg, rfd, mode, d, dlen;
        bit hold;
        checks         = 0;
        errors         = 0;
        cur_s          = -1;
        rst            = 1'b1;
        vif.req_valid  = 1'b0;
        vif.req_slot   = '0;
        vif.req_change = '0;
        vif.req_refund = '0;
        vif.drop_sense = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_reset_outputs();
        rst = 1'b0;
        @(negedge clk);
        check_reset_outputs();

        // Normal vend: drop in the fifth WAIT_DROP cycle, three coins.
        run_txn(2, 3, 7, M + 4, 1, 1'b0, -1);
        // Jam: no drop at all, refund paid instead of change.
        run_txn(1, 2, 6, -1, 0, 1'b0, -1);
        // Zero change, drop latched during the third motor cycle.
        run_txn(0, 0, 5, 2, 1, 1'b0, -1);
        // Drop on the last allowed wait cycle, maximum change.
        run_txn(3, 15, 4, M + T - 1, 1, 1'b0, -1);
        // Drop arriving too late, zero refund.
        run_txn(2, 5, 0, M + T + 3, 4, 1'b0, -1);

        // Reset during the gap after the first of three coins.
        run_txn(0, 3, 7, 2, 1, 1'b0, M + 3);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        cur_s = -1;
        check_reset_outputs();
        rst = 1'b0;
        run_txn(3, 1, 2, M + 2, 1, 1'b0, -1);

        // Request held with a wandering slot while busy, then back-to-back.
        run_txn(1, 2, 3, 3, 1, 1'b1, -1);
        run_txn(2, 1, 1, M, 1, 1'b1, -1);
        run_txn(0, 0, 0, 1, 1, 1'b0, -1);

        for (int k = 0; k < 25; k++) begin
            slot = $urandom_range(0, N_SLOTS - 1);
            chg  = $urandom_range(0, 15);
            rfd  = $urandom_range(0, 15);
            mode = $urandom_range(0, 3);
            dlen = $urandom_range(1, 3);
            hold = 1'($urandom_range(0, 1));
            case (mode)
                0:       d = $urandom_range(0, M - 1);
                1:       d = $urandom_range(M, M + T - 1);
                2:       d = -1;
                default: d = $urandom_range(M + T, M + T + 30);
            endcase
            run_txn(slot, chg, rfd, d, dlen, hold, -1);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
